mem_arbiter: RTL and testbench

Shares the single byte-wide memory port between the memory masters: the wasm parser/loader (index 0), the CPU (index 1), and any later masters. It grants exclusive, lockable ownership of the port to one requester at a time. The owner's `addr`/`data_in`/`memory_read_en`/`memory_write_en` reach memory, and `memory_ready`/`data_out` are routed back to it. The per-requester grant drives each master's `mem_access` input.

---
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals around mem_arbiter.
// slave = arbiter view, master = requesters/memory view.
interface mem_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        grant;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*8-1:0]      req_wdata;
  logic [N_REQ-1:0]        req_rd_en;
  logic [N_REQ-1:0]        req_wr_en;
  logic [ADDR_W-1:0]       mem_addr;
  logic [7:0]              mem_wdata;
  logic                    mem_rd_en;
  logic                    mem_wr_en;
  logic                    mem_ready;
  logic [7:0]              mem_rdata;
  logic [N_REQ-1:0]        req_ready;
  logic [7:0]              req_rdata;
  logic [2:0]              owner;
  logic                    hold_timeout;

  modport slave (
    input  req, req_addr, req_wdata, req_rd_en, req_wr_en, mem_ready, mem_rdata,
    output grant, mem_addr, mem_wdata, mem_rd_en, mem_wr_en, req_ready, req_rdata,
           owner, hold_timeout
  );

  modport master (
    output req, req_addr, req_wdata, req_rd_en, req_wr_en, mem_ready, mem_rdata,
    input  grant, mem_addr, mem_wdata, mem_rd_en, mem_wr_en, req_ready, req_rdata,
           owner, hold_timeout
  );
endinterface

// File: rtl/mem_arbiter.sv
// Lockable single-owner arbiter for the shared byte-wide memory port.
// Optional MEM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
module mem_arbiter #(
  parameter int N_REQ    = 2,
  parameter int ADDR_W   = 32,
  parameter int MAX_HOLD = 1024
) (
  input logic         clk,
  input logic         rst_n,
  mem_arbiter_if.slave bus
);

  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWNED   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t           state_r;
  logic [N_REQ-1:0] grant_r;
  logic [2:0]       owner_r;
  logic             hold_timeout_r;
  logic [CNT_W-1:0] hold_cnt_r;

  logic [N_REQ-1:0] owner_sel_s;
  logic             owner_req_s;
  logic [2:0]       winner_s;

  function automatic logic [2:0] lowest_set(input logic [N_REQ-1:0] r);
    logic [2:0] w;
    w = 3'd0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (r[i]) begin
        w = 3'(i);
      end
    end
    return w;
  endfunction

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [2:0]       last_r;
  logic [2:0]       start_s;
  logic [N_REQ-1:0] hi_mask_s;
  logic [N_REQ-1:0] hi_req_s;

  assign start_s = (last_r >= 3'(N_REQ - 1)) ? 3'd0 : last_r + 3'd1;

  // Requesters at or above the rotating start index get first pick.
  always_comb begin
    hi_mask_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      hi_mask_s[i] = (3'(i) >= start_s);
    end
  end

  assign hi_req_s = bus.req & hi_mask_s;
  assign winner_s = (|hi_req_s) ? lowest_set(hi_req_s) : lowest_set(bus.req);

  // Pointer reset to N_REQ-1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r <= 3'(N_REQ - 1);
    end else if (state_r == IDLE && (|bus.req)) begin
      last_r <= winner_s;
    end else begin
      last_r <= last_r;
    end
  end
`else
  assign winner_s = lowest_set(bus.req);
`endif

  // Owner decode; empty outside OWNED so the port stays quiet.
  always_comb begin
    owner_sel_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      owner_sel_s[i] = (state_r == OWNED) && (owner_r == 3'(i));
    end
  end

  assign owner_req_s = |(owner_sel_s & bus.req);

  // Port mux: AND-OR of the owner's slices.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = 8'h00;
    bus.mem_rd_en = 1'b0;
    bus.mem_wr_en = 1'b0;
    bus.req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      bus.mem_addr  = bus.mem_addr  | ({ADDR_W{owner_sel_s[i]}} & bus.req_addr[i*ADDR_W +: ADDR_W]);
      bus.mem_wdata = bus.mem_wdata | ({8{owner_sel_s[i]}} & bus.req_wdata[i*8 +: 8]);
      bus.mem_rd_en = bus.mem_rd_en | (owner_sel_s[i] & bus.req_rd_en[i]);
      bus.mem_wr_en = bus.mem_wr_en | (owner_sel_s[i] & bus.req_wr_en[i]);
      bus.req_ready[i] = owner_sel_s[i] & bus.mem_ready;
    end
  end

  // hold_cnt_r counts OWNED cycles including the current one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      grant_r        <= '0;
      owner_r        <= 3'd0;
      hold_timeout_r <= 1'b0;
      hold_cnt_r     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|bus.req) begin
            state_r        <= OWNED;
            grant_r        <= N_REQ'(1) << winner_s;
            owner_r        <= winner_s;
            hold_cnt_r     <= (MAX_HOLD != 0) ? CNT_W'(1) : '0;
            hold_timeout_r <= hold_timeout_r | (MAX_HOLD == 1);
          end else begin
            grant_r <= '0;
          end
        end
        OWNED: begin
          if (!owner_req_s) begin
            state_r <= RELEASE;
            grant_r <= '0;
          end else if ((MAX_HOLD != 0) && (hold_cnt_r != CNT_W'(MAX_HOLD))) begin
            hold_cnt_r <= hold_cnt_r + CNT_W'(1);
            if (hold_cnt_r == CNT_W'(MAX_HOLD - 1)) begin
              hold_timeout_r <= 1'b1;
            end
          end
        end
        RELEASE: begin
          // Wait for the previous owner's transfer to retire.
          if (!bus.mem_ready) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          grant_r <= '0;
        end
      endcase
    end
  end

  assign bus.grant        = grant_r;
  assign bus.owner        = owner_r;
  assign bus.hold_timeout = hold_timeout_r;
  assign bus.req_rdata    = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (N_REQ=2, MAX_HOLD=8); honours MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  mem_arbiter_if #(.N_REQ(2), .ADDR_W(32)) bus ();

  mem_arbiter #(.N_REQ(2), .ADDR_W(32), .MAX_HOLD(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [1:0] arb_exp [4];
  bit         seen;

  initial begin
    n_vec = 0;
    n_err = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    arb_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    arb_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    rst_n         = 1'b0;
    bus.req       = 2'b11;
    bus.req_addr  = {32'h0000_0010, 32'h0000_00A0};
    bus.req_wdata = {8'h5A, 8'hC3};
    bus.req_rd_en = 2'b11;
    bus.req_wr_en = 2'b00;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 8'h00;

    // Reset with both requesting
    repeat (2) tick();
    check_vec("rst_grant", 64'(bus.grant), 64'h0);
    check_vec("rst_rd_en", 64'(bus.mem_rd_en), 64'h0);
    check_vec("rst_timeout", 64'(bus.hold_timeout), 64'h0);
    check_vec("rst_owner", 64'(bus.owner), 64'h0);
    rst_n = 1'b1;
    tick();
    check_vec("first_grant", 64'(bus.grant), 64'h1);
    check_vec("first_addr", 64'(bus.mem_addr), 64'hA0);
    check_vec("first_rd_en", 64'(bus.mem_rd_en), 64'h1);

    // Watchdog: first OWNED cycle was just checked
    repeat (6) tick();
    check_vec("wd_cycle7", 64'(bus.hold_timeout), 64'h0);
    tick();
    check_vec("wd_cycle8", 64'(bus.hold_timeout), 64'h1);
    check_vec("wd_grant", 64'(bus.grant), 64'h1);

    // Lock: CPU keeps requesting while parser owns
    for (int i = 0; i < 12; i++) begin
      tick();
      check_vec("lock_grant", 64'(bus.grant), 64'h1);
    end

    // Parser releases while memory still busy
    bus.req       = 2'b10;
    bus.mem_ready = 1'b1;
    tick();
    check_vec("rel_grant", 64'(bus.grant), 64'h0);
    check_vec("rel_addr", 64'(bus.mem_addr), 64'h0);
    check_vec("rel_rd_en", 64'(bus.mem_rd_en), 64'h0);
    check_vec("rel_sticky", 64'(bus.hold_timeout), 64'h1);
    repeat (2) begin
      tick();
      check_vec("rel_wait", 64'(bus.grant), 64'h0);
    end
    bus.mem_ready = 1'b0;
    tick();
    check_vec("turnaround", 64'(bus.grant), 64'h0);
    tick();
    check_vec("cpu_grant", 64'(bus.grant), 64'h2);
    check_vec("cpu_owner", 64'(bus.owner), 64'h1);

    // Single owner read
    bus.mem_rdata = 8'h41;
    bus.mem_ready = 1'b1;
    #1;
    check_vec("rd_addr", 64'(bus.mem_addr), 64'h10);
    check_vec("rd_ready", 64'(bus.req_ready), 64'h2);
    check_vec("rd_rdata", 64'(bus.req_rdata), 64'h41);
    check_vec("rd_en", 64'(bus.mem_rd_en), 64'h1);
    check_vec("rd_no_wr", 64'(bus.mem_wr_en), 64'h0);

    // Write, then reset mid-write
    bus.req_wr_en = 2'b10;
    #1;
    check_vec("wr_en", 64'(bus.mem_wr_en), 64'h1);
    check_vec("wr_data", 64'(bus.mem_wdata), 64'h5A);
    #1;
    rst_n = 1'b0;
    #1;
    check_vec("async_wr_en", 64'(bus.mem_wr_en), 64'h0);
    check_vec("async_grant", 64'(bus.grant), 64'h0);
    check_vec("async_timeout", 64'(bus.hold_timeout), 64'h0);
    check_vec("async_ready", 64'(bus.req_ready), 64'h0);
    check_vec("async_addr", 64'(bus.mem_addr), 64'h0);
    bus.req       = 2'b00;
    bus.req_wr_en = 2'b00;
    bus.mem_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check_vec("no_glitch", 64'(bus.grant), 64'h0);

    // Arbitration policy: both request, drop after each grant
    for (int k = 0; k < 4; k++) begin
      bus.req = 2'b11;
      seen    = 1'b0;
      for (int w = 0; w < 8 && !seen; w++) begin
        tick();
        if (bus.grant != 2'b00) begin
          seen = 1'b1;
        end
      end
      check_vec($sformatf("arb_%0d", k), 64'(bus.grant), 64'(arb_exp[k]));
      bus.req = 2'b00;
      repeat (2) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
